// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop input sync, centre sampling, valid/frame-error strobes and a per-byte LED toggle.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote over the last three rx_s samples at each sample point.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       led
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
    localparam int HALF_CNT     = (BAUD_CNT_MAX + 1) / 2 - 1;
    localparam int CW           = $clog2(BAUD_CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic            rx_meta, rx_s, rx_d;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            fall, half_hit, full_hit, smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall     = !rx_s && rx_d;
    assign half_hit = (baud_cnt == CW'(HALF_CNT));
    assign full_hit = (baud_cnt == CW'(BAUD_CNT_MAX));

`ifdef UART_RX_MAJORITY_EN
    // hist[0]/hist[1] hold rx_s from counts N-1/N-2 when the decision is made at N.
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rx_s};
    end
    assign smp = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
`else
    assign smp = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (fall) state_n = START;
            START: if (half_hit) state_n = smp ? IDLE : DATA;
            DATA:  if (full_hit && bit_cnt == 3'd7) state_n = STOP;
            STOP:  if (full_hit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            led       <= 1'b1;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= (state_n != IDLE);
            case (state)
                IDLE: baud_cnt <= '0;
                START: begin
                    if (half_hit) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (full_hit) begin
                        baud_cnt  <= '0;
                        shift_reg <= {smp, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (full_hit) begin
                        baud_cnt <= '0;
                        // A bad stop bit leaves rx_data and led untouched.
                        if (smp) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            led      <= ~led;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: baud_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx with a scaled-down baud ratio (16 clk per bit) to keep runs short.
module tb_uart_byte_rx;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int BMAX     = CLK_FREQ / BAUD - 1;
    localparam int HALF     = (BMAX + 1) / 2 - 1;
    localparam int BIT      = BMAX + 1;
    localparam int LAT_EXP  = 2 + HALF + 9 * BIT + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy, led;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, v_cnt = 0, e_cnt = 0, v_time = 0;
    logic [7:0] v_q[$];

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Counts high cycles of each strobe, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (rx_valid) begin
            v_cnt++;
            v_time = cyc;
            v_q.push_back(rx_data);
        end
        if (frame_err) e_cnt++;
        if (rx_valid || frame_err) begin
            n_cmp++;
            assert (!(rx_valid && frame_err)) else begin
                n_err++;
                $error("FAIL strobe_overlap: observed valid=%0b err=%0b expected not both", rx_valid, frame_err);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input int glitch, input int ncyc);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            uart_rx = fr[c / BIT] ^ (c == glitch);
            tick(1);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (v_q.size() > 0) ? v_q.pop_front() : 8'hxx;
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    initial begin
        int v0, e0, t0, lat;
        logic exp_led;
        rst = 1'b1;
        uart_rx = 1'b1;
        exp_led = 1'b1;
        tick(3);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_led", {31'd0, led}, 1);
        rst = 1'b0;
        tick(10);

        // single frame 0x55 with latency measurement
        v0 = v_cnt; e0 = e_cnt; t0 = cyc;
        send_frame(8'h55, 1'b1, -1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        exp_led = ~exp_led;
        lat = v_time - t0;
        check("f55_cnt", v_cnt - v0, 1);
        pop_check("f55_data", 8'h55);
        check("f55_lat_ok", {31'd0, (lat >= LAT_EXP - 2) && (lat <= LAT_EXP + 2)}, 1);
        check("f55_led", {31'd0, led}, {31'd0, exp_led});
        check("f55_ferr", e_cnt - e0, 0);
        check("f55_busy", {31'd0, busy}, 0);

        // back-to-back frames, zero idle bits
        v0 = v_cnt;
        send_frame(8'hA3, 1'b1, -1, 10 * BIT);
        send_frame(8'h0F, 1'b1, -1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        exp_led = ~exp_led;
        exp_led = ~exp_led;
        check("b2b_cnt", v_cnt - v0, 2);
        pop_check("b2b_a3", 8'hA3);
        pop_check("b2b_0f", 8'h0F);
        check("b2b_led", {31'd0, led}, {31'd0, exp_led});
        check("b2b_data", {24'd0, rx_data}, 32'h0F);

        // short low pulse (under half a bit): false start rejected
        v0 = v_cnt; e0 = e_cnt;
        uart_rx = 1'b0;
        tick(5);
        check("glt_busy_hi", {31'd0, busy}, 1);
        uart_rx = 1'b1;
        tick(20);
        check("glt_busy_lo", {31'd0, busy}, 0);
        check("glt_valid", v_cnt - v0, 0);
        check("glt_ferr", e_cnt - e0, 0);
        send_frame(8'h3C, 1'b1, -1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        exp_led = ~exp_led;
        check("f3c_cnt", v_cnt - v0, 1);
        pop_check("f3c_data", 8'h3C);

        // bad stop bit, line stuck low, then a good frame
        v0 = v_cnt; e0 = e_cnt;
        send_frame(8'h81, 1'b0, -1, 10 * BIT);
        uart_rx = 1'b0;
        tick(3 * BIT);
        check("fe_cnt", e_cnt - e0, 1);
        check("fe_valid", v_cnt - v0, 0);
        check("fe_data", {24'd0, rx_data}, 32'h3C);
        check("fe_led", {31'd0, led}, {31'd0, exp_led});
        check("fe_busy", {31'd0, busy}, 0);
        uart_rx = 1'b1;
        tick(20);
        send_frame(8'h7E, 1'b1, -1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        exp_led = ~exp_led;
        check("f7e_cnt", v_cnt - v0, 1);
        pop_check("f7e_data", 8'h7E);
        check("f7e_ferr", e_cnt - e0, 1);

        // reset in the middle of the data bits
        v0 = v_cnt; e0 = e_cnt;
        send_frame(8'hFF, 1'b1, -1, 4 * BIT);
        check("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(1);
        exp_led = 1'b1;
        check("mrst_data", {24'd0, rx_data}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 0);
        check("mrst_led", {31'd0, led}, 1);
        tick(3);
        rst = 1'b0;
        tick(20);
        check("mrst_valid", v_cnt - v0, 0);
        check("mrst_ferr", e_cnt - e0, 0);
        send_frame(8'h12, 1'b1, -1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        exp_led = ~exp_led;
        check("f12_cnt", v_cnt - v0, 1);
        pop_check("f12_data", 8'h12);
        check("f12_led", {31'd0, led}, {31'd0, exp_led});

        // one-clock high glitch landing on the data bit 0 sample point
        v0 = v_cnt;
        send_frame(8'h00, 1'b1, BIT + HALF + 1, 10 * BIT);
        uart_rx = 1'b1;
        tick(20);
        check("g00_cnt", v_cnt - v0, 1);
`ifdef UART_RX_MAJORITY_EN
        pop_check("g00_data", 8'h00);
`else
        pop_check("g00_data", 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
